alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits, legal range 4..64.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 in_valid  input  1  operand/opcode presented this cycle.
REQ-005 in_ready  output  1  block accepts a transaction this cycle.
REQ-006 in_a  input  WIDTH  operand A.
REQ-007 in_b  input  WIDTH  operand B.
REQ-008 ctrl_aluop  input  3  operation select, encoding per REQ-013.
REQ-009 out_valid  output  1  result registers hold a valid result.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out  output  WIDTH  result.
REQ-012 flag_zero, flag_neg, flag_carry, flag_ovf  output  1 each  status flags for the result on out.

Function
REQ-013 Opcodes: 000 SUB out=b-a; 001 NEG out=-a; 010 INC out=a+1; 011 AND out=a&b; 100 ADD out=b+a; 101 MUL out=low WIDTH bits of a*b (unsigned); 110 OR out=a|b; 111 PASS out=a.
REQ-014 Accept = in_valid && in_ready; operands and opcode are captured only on accept.
REQ-015 Deliver = out_valid && out_ready; out and flags are held stable while out_valid && !out_ready.
REQ-016 in_ready = (state==IDLE) && (!out_valid || out_ready); accept and deliver in the same cycle is legal (full throughput for non-MUL ops).
REQ-017 Non-MUL ops: result and flags registered on the accepting edge; out_valid high the next cycle (latency 1).
REQ-018 MUL: FSM IDLE -> MUL_RUN on accept; MUL_RUN runs exactly WIDTH cycles of shift-add; on the last, result and flags load and FSM -> IDLE; out_valid rises after WIDTH+1 edges from accept.
REQ-019 in_ready is low throughout MUL_RUN regardless of out_ready.
REQ-020 out_valid clears on deliver unless a new result loads on the same edge.
REQ-021 flag_zero = (out==0); flag_neg = out[WIDTH-1], for every op.
REQ-022 flag_carry: carry-out of WIDTH-bit adder for ADD/INC; SUB computed as b+~a+1, carry=1 iff b>=a unsigned; NEG computed as 0+~a+1, carry=1 iff a==0; MUL carry=1 iff upper WIDTH product bits nonzero; AND/OR/PASS carry=0.
REQ-023 flag_ovf: signed two's-complement overflow for ADD/SUB/INC/NEG (e.g. NEG of 1<<(WIDTH-1) sets ovf); 0 for other ops.
REQ-024 All arithmetic wraps modulo 2^WIDTH; no saturation.

Reset
REQ-025 While rst high at a clock edge: out_valid=0, out=0, all flags=0, FSM=IDLE, multiplier accumulators cleared.
REQ-026 rst during MUL_RUN aborts the multiply; no result is ever delivered for it.
REQ-027 in_ready is 0 during a cycle in which rst is high and 1 the cycle after rst deasserts.

Structure
REQ-028 Package alu_pkg holds opcode constants (OP_SUB..OP_PASS) and the FSM state enum (IDLE, MUL_RUN).
REQ-029 Iterative multiplier is a sub-module alu_mul_iter (start, a, b -> done, product[2*WIDTH-1:0]), parametrised by WIDTH.
REQ-030 Adder/logic/flag path stays inside alu_pipe as one registered stage.

Verification (WIDTH=32)
REQ-031 ADD a=0xFFFFFFFF b=1, out_ready=1 -> next cycle out=0, zero=1, carry=1, ovf=0.
REQ-032 SUB a=5 b=3 -> out=0xFFFFFFFE, neg=1, carry=0; NEG a=0x80000000 -> out=0x80000000, ovf=1.
REQ-033 MUL a=0x10000 b=0x10000 -> in_ready low 32 cycles, out_valid at edge 33, out=0, carry=1, zero=1.
REQ-034 Back-to-back INC a=0..9, out_ready toggling 1/0 -> results 1..10 in order, none lost or duplicated, out stable while stalled.
REQ-035 rst asserted 10 cycles into MUL -> out_valid stays 0, in_ready=1 the cycle after rst drops, next ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined ALU.
//   - OP_* : 3-bit opcode encodings driven on ctrl_aluop
//   - state_t : control FSM states (IDLE, MUL_RUN)
//   - STATE_W : width of the debug state port
package alu_pkg;

    localparam logic [2:0] OP_SUB  = 3'b000;  // out = b - a
    localparam logic [2:0] OP_NEG  = 3'b001;  // out = -a
    localparam logic [2:0] OP_INC  = 3'b010;  // out = a + 1
    localparam logic [2:0] OP_AND  = 3'b011;  // out = a & b
    localparam logic [2:0] OP_ADD  = 3'b100;  // out = b + a
    localparam logic [2:0] OP_MUL  = 3'b101;  // out = low half of a * b
    localparam logic [2:0] OP_OR   = 3'b110;  // out = a | b
    localparam logic [2:0] OP_PASS = 3'b111;  // out = a

    localparam int STATE_W = 1;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 1'b0,
        MUL_RUN = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: unsigned shift-add multiplier, one partial product per clock.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (aborts a running multiply)
//   start     : load a/b and begin; ignored bits of a previous run are discarded
//   a, b      : WIDTH-bit unsigned operands (sampled only when start is high)
//   done      : high during the last of WIDTH step cycles
//   product   : full 2*WIDTH-bit product, valid in the cycle done is high
// The product is presented combinationally from the final step so that the
// consumer can register it on the same edge the multiplier retires.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic               busy;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mcand;
    // Upper half accumulates partial sums, lower half holds the remaining
    // multiplier bits; each step shifts the whole register right by one.
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [WIDTH:0]     partial;

    always_comb begin
        partial  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {partial, acc[WIDTH-1:1]};
        done     = busy && (count == CW'(WIDTH - 1));
        product  = acc_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            mcand <= '0;
            acc   <= '0;
        end else if (start) begin
            busy  <= 1'b1;
            count <= '0;
            mcand <= a;
            acc   <= {{WIDTH{1'b0}}, b};
        end else if (busy) begin
            acc   <= acc_next;
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: single-stage registered ALU with an iterative multiplier.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake; in_a, in_b, ctrl_aluop
//   out_valid/out_ready      : output handshake; out plus flag_zero/neg/carry/ovf
//   dbg_state                : current control FSM state (IDLE / MUL_RUN)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer must hold its payload until that edge; the
// consumer side of this block holds out and the flags stable while
// out_valid && !out_ready. in_ready depends combinationally on out_ready so
// a result can be delivered and a new operation accepted on the same edge.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         ctrl_aluop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out,
    output logic               flag_zero,
    output logic               flag_neg,
    output logic               flag_carry,
    output logic               flag_ovf,
    output logic [STATE_W-1:0] dbg_state
);

    state_t             state;
    logic               accept;
    logic               deliver;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    // Shared adder: every arithmetic op is x + y + cin.
    logic [WIDTH-1:0]   add_x;
    logic [WIDTH-1:0]   add_y;
    logic               add_cin;
    logic [WIDTH:0]     add_sum;
    logic               add_ovf;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;

    assign in_ready  = !rst && (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
    assign mul_start = accept && (ctrl_aluop == OP_MUL);
    assign dbg_state = state;

    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        case (ctrl_aluop)
            OP_SUB: begin  // b + ~a + 1
                add_x   = in_b;
                add_y   = ~in_a;
                add_cin = 1'b1;
            end
            OP_NEG: begin  // 0 + ~a + 1
                add_y   = ~in_a;
                add_cin = 1'b1;
            end
            OP_INC: begin
                add_x   = in_a;
                add_cin = 1'b1;
            end
            OP_ADD: begin
                add_x = in_b;
                add_y = in_a;
            end
            default: begin
            end
        endcase
    end

    assign add_sum = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    // Signed overflow: both addends share a sign that the result does not.
    assign add_ovf = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != add_x[WIDTH-1]);

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (ctrl_aluop)
            OP_SUB, OP_NEG, OP_INC, OP_ADD: begin
                alu_res   = add_sum[WIDTH-1:0];
                alu_carry = add_sum[WIDTH];
                alu_ovf   = add_ovf;
            end
            OP_AND:  alu_res = in_a & in_b;
            OP_OR:   alu_res = in_a | in_b;
            OP_PASS: alu_res = in_a;
            default: begin
            end
        endcase
    end

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (in_a),
        .b       (in_b),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out        <= '0;
            flag_zero  <= 1'b0;
            flag_neg   <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (mul_start) state <= MUL_RUN;
                MUL_RUN: if (mul_done)  state <= IDLE;
                default: state <= IDLE;
            endcase

            if (accept && (ctrl_aluop != OP_MUL)) begin
                out        <= alu_res;
                flag_zero  <= (alu_res == '0);
                flag_neg   <= alu_res[WIDTH-1];
                flag_carry <= alu_carry;
                flag_ovf   <= alu_ovf;
                out_valid  <= 1'b1;
            end else if ((state == MUL_RUN) && mul_done) begin
                out        <= mul_product[WIDTH-1:0];
                flag_zero  <= (mul_product[WIDTH-1:0] == '0);
                flag_neg   <= mul_product[WIDTH-1];
                flag_carry <= |mul_product[2*WIDTH-1:WIDTH];
                flag_ovf   <= 1'b0;
                out_valid  <= 1'b1;
            end else if (deliver) begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  ctrl_aluop;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        flag_zero;
    logic        flag_neg;
    logic        flag_carry;
    logic        flag_ovf;
    logic [STATE_W-1:0] dbg_state;

    int total;
    int bad;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .ctrl_aluop (ctrl_aluop),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .flag_zero  (flag_zero),
        .flag_neg   (flag_neg),
        .flag_carry (flag_carry),
        .flag_ovf   (flag_ovf),
        .dbg_state  (dbg_state)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for exactly one edge (caller ensures in_ready).
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        ctrl_aluop = op;
        in_a       = a;
        in_b       = b;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        total++; if (out !== 32'h0) begin bad++; $display("FAIL rst_out got=%h exp=00000000", out); end
        total++; if ({flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0000) begin
            bad++; $display("FAIL rst_flags got=%b exp=0000", {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        total++; if (dbg_state !== STATE_W'(IDLE)) begin bad++; $display("FAIL rst_state got=%b exp=0", dbg_state); end
        rst = 1'b0;
        tick();
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        issue(OP_ADD, 32'hFFFF_FFFF, 32'h1);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", out_valid); end
        total++; if (out !== 32'h0) begin bad++; $display("FAIL add_out got=%h exp=00000000", out); end
        total++; if ({flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b1010) begin
            bad++; $display("FAIL add_flags zncv got=%b exp=1010", {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        tick();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL add_deliver_clear got=%b exp=0", out_valid); end
        issue(OP_ADD, 32'h7FFF_FFFF, 32'h1);
        total++; if (out !== 32'h8000_0000) begin bad++; $display("FAIL add_ovf_out got=%h exp=80000000", out); end
        total++; if ({flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0101) begin
            bad++; $display("FAIL add_ovf_flags zncv got=%b exp=0101", {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        drain();
    endtask

    task automatic test_sub_neg();
        out_ready = 1'b1;
        issue(OP_SUB, 32'd5, 32'd3);
        total++; if (out !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_out got=%h exp=fffffffe", out); end
        total++; if ({flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0100) begin
            bad++; $display("FAIL sub_flags zncv got=%b exp=0100", {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        issue(OP_SUB, 32'd5, 32'd7);
        total++; if (out !== 32'd2 || flag_carry !== 1'b1) begin
            bad++; $display("FAIL sub_pos got=%h c=%b exp=00000002 c=1", out, flag_carry); end
        issue(OP_SUB, 32'h0000_0001, 32'h8000_0000);
        total++; if (out !== 32'h7FFF_FFFF || flag_ovf !== 1'b1 || flag_carry !== 1'b1) begin
            bad++; $display("FAIL sub_ovf got=%h v=%b c=%b exp=7fffffff v=1 c=1", out, flag_ovf, flag_carry); end
        issue(OP_NEG, 32'h8000_0000, 32'h0);
        total++; if (out !== 32'h8000_0000) begin bad++; $display("FAIL neg_min_out got=%h exp=80000000", out); end
        total++; if ({flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0101) begin
            bad++; $display("FAIL neg_min_flags zncv got=%b exp=0101", {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        issue(OP_NEG, 32'h0, 32'h0);
        total++; if (out !== 32'h0 || {flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b1010) begin
            bad++; $display("FAIL neg_zero got=%h zncv=%b exp=00000000 zncv=1010", out,
                            {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        issue(OP_NEG, 32'd1, 32'h0);
        total++; if (out !== 32'hFFFF_FFFF || flag_carry !== 1'b0) begin
            bad++; $display("FAIL neg_one got=%h c=%b exp=ffffffff c=0", out, flag_carry); end
        drain();
    endtask

    task automatic test_logic_inc();
        out_ready = 1'b1;
        issue(OP_AND, 32'hF0F0_1234, 32'hFF00_FF00);
        total++; if (out !== 32'hF000_1200 || {flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0100) begin
            bad++; $display("FAIL and got=%h zncv=%b exp=f0001200 zncv=0100", out,
                            {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        issue(OP_OR, 32'hF0F0_1234, 32'hFF00_FF00);
        total++; if (out !== 32'hFFF0_FF34) begin bad++; $display("FAIL or got=%h exp=fff0ff34", out); end
        issue(OP_AND, 32'h0F0F_0F0F, 32'hF0F0_F0F0);
        total++; if (out !== 32'h0 || flag_zero !== 1'b1) begin
            bad++; $display("FAIL and_zero got=%h z=%b exp=00000000 z=1", out, flag_zero); end
        issue(OP_PASS, 32'h8000_0001, 32'hFFFF_FFFF);
        total++; if (out !== 32'h8000_0001 || {flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0100) begin
            bad++; $display("FAIL pass got=%h zncv=%b exp=80000001 zncv=0100", out,
                            {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        issue(OP_INC, 32'h7FFF_FFFF, 32'h0);
        total++; if (out !== 32'h8000_0000 || {flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0101) begin
            bad++; $display("FAIL inc_ovf got=%h zncv=%b exp=80000000 zncv=0101", out,
                            {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        issue(OP_INC, 32'hFFFF_FFFF, 32'h0);
        total++; if (out !== 32'h0 || {flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b1010) begin
            bad++; $display("FAIL inc_wrap got=%h zncv=%b exp=00000000 zncv=1010", out,
                            {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        drain();
    endtask

    task automatic test_mul();
        int lat;
        logic [31:0] held;
        // Hold the result so stability under stall is observable.
        out_ready = 1'b0;
        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000);
        out_ready = 1'b1;  // in_ready must stay low regardless
        for (int i = 0; i < 32; i++) begin
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
                bad++; $display("FAIL mul_busy cyc=%0d in_ready=%b out_valid=%b exp=0/0", i, in_ready, out_valid); end
            if (i == 30) out_ready = 1'b0;
            tick();
        end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mul_latency out_valid=%b exp=1", out_valid); end
        total++; if (out !== 32'h0 || {flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b1010) begin
            bad++; $display("FAIL mul_big got=%h zncv=%b exp=00000000 zncv=1010", out,
                            {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        held = out;
        tick();
        tick();
        total++; if (out_valid !== 1'b1 || out !== held || in_ready !== 1'b0) begin
            bad++; $display("FAIL mul_stall valid=%b out=%h in_ready=%b exp=1/%h/0", out_valid, out, in_ready, held); end
        drain();

        out_ready = 1'b1;
        issue(OP_MUL, 32'd7, 32'd9);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        total++; if (lat != 32) begin bad++; $display("FAIL mul_small_latency got=%0d exp=32", lat); end
        total++; if (out !== 32'd63 || {flag_zero, flag_neg, flag_carry, flag_ovf} !== 4'b0000) begin
            bad++; $display("FAIL mul_small got=%h zncv=%b exp=0000003f zncv=0000", out,
                            {flag_zero, flag_neg, flag_carry, flag_ovf}); end
        tick();

        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
        total++; if (out !== 32'd1 || flag_carry !== 1'b1 || lat != 32) begin
            bad++; $display("FAIL mul_max got=%h c=%b lat=%0d exp=00000001 c=1 lat=32", out, flag_carry, lat); end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_q[$];
        logic [31:0] held;
        logic [31:0] exp_v;
        logic        stalled;
        int sent;
        int got;
        sent = 0; got = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 100 && got < 10; cyc++) begin
            out_ready  = (cyc % 2 == 0);
            in_valid   = (sent < 10);
            in_a       = 32'(sent);
            in_b       = 32'h0;
            ctrl_aluop = OP_INC;
            #1;
            if (stalled) begin
                total++; if (out_valid !== 1'b1 || out !== held) begin
                    bad++; $display("FAIL b2b_stall cyc=%0d valid=%b out=%h exp=1/%h", cyc, out_valid, out, held); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_extra got=%h exp=none", out);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (out !== exp_v) begin bad++; $display("FAIL b2b_data got=%h exp=%h", out, exp_v); end
                end
                got++;
            end
            stalled = out_valid && !out_ready;
            held    = out;
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(sent + 1));
                sent++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        total++; if (got != 10 || sent != 10 || exp_q.size() != 0) begin
            bad++; $display("FAIL b2b_count got=%0d sent=%0d left=%0d exp=10/10/0", got, sent, exp_q.size()); end
        drain();
    endtask

    task automatic test_mul_reset();
        logic seen;
        out_ready = 1'b1;
        issue(OP_MUL, 32'd3, 32'd5);
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mrst_ready_in_rst got=%b exp=0", in_ready); end
        tick();
        rst = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL mrst_after ready=%b valid=%b exp=1/0", in_ready, out_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid === 1'b1) seen = 1'b1;
            tick();
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mrst_ghost_result got=1 exp=0"); end
        issue(OP_ADD, 32'd2, 32'd3);
        total++; if (out_valid !== 1'b1 || out !== 32'd5) begin
            bad++; $display("FAIL mrst_add valid=%b out=%h exp=1/00000005", out_valid, out); end
        drain();
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_a       = '0;
        in_b       = '0;
        ctrl_aluop = OP_PASS;
        out_ready  = 1'b0;

        test_reset();
        test_add();
        test_sub_neg();
        test_logic_inc();
        test_mul();
        test_back_to_back();
        test_mul_reset();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
